// File: rtl/sop_eval_engine.sv
// Sequential sum-of-products evaluator: a loadable cube table is scanned CPC cubes
// per clock against a latched input vector; the OR of matching cube outputs is returned.
module sop_eval_engine #(
  parameter int N_IN       = 28,
  parameter int N_OUT      = 3,
  parameter int N_CUBES    = 64,
  parameter int CPC        = 1,
  parameter bit EARLY_EXIT = 1'b0,
  localparam int AW        = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_out,
  input  logic             cfg_len_we,
  input  logic [AW:0]      cfg_len,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             busy
);

  localparam logic [AW:0] CPC_W   = (AW+1)'(CPC);
  localparam logic [AW:0] MAX_LEN = (AW+1)'(N_CUBES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      idx_q, idx_d;
  logic [N_IN-1:0]  in_q, in_d;
  logic [N_OUT-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             cfg_err_q, cfg_err_d;

  logic [N_IN-1:0]  care_mem [N_CUBES];
  logic [N_IN-1:0]  val_mem  [N_CUBES];
  logic [N_OUT-1:0] out_mem  [N_CUBES];

  logic             idle;
  logic             tbl_we;
  logic             len_we;
  logic [AW:0]      len_sat;
  logic [AW:0]      cidx [CPC];
  logic [N_OUT-1:0] hit;

  assign idle    = (state_q == IDLE);
  assign tbl_we  = cfg_we & idle;
  assign len_we  = cfg_len_we & idle;
  assign len_sat = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;

  // OR of out masks of the matching cubes in the current window, ignoring cubes past count.
  always_comb begin
    hit = '0;
    for (int j = 0; j < CPC; j++) begin
      cidx[j] = idx_q + (AW+1)'(j);
      if ((cidx[j] < count_q) &&
          (((in_q ^ val_mem[cidx[j][AW-1:0]]) & care_mem[cidx[j][AW-1:0]]) == '0)) begin
        hit = hit | out_mem[cidx[j][AW-1:0]];
      end
    end
  end

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_d        = in_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    count_d     = len_we ? len_sat : count_q;
    cfg_err_d   = ~idle & (cfg_we | cfg_len_we);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d  = in_data;
          acc_d = '0;
          idx_d = '0;
          // count_d already includes a same-cycle length write
          if (count_d == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        acc_d = acc_q | hit;
        idx_d = idx_q + CPC_W;
        if ((idx_q + CPC_W >= count_q) || (EARLY_EXIT && (&acc_d))) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      in_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      in_q        <= in_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // NOTE: only the out masks are reset; a cube with a zero mask contributes nothing,
  // so care/val can stay un-reset storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CUBES; i++) out_mem[i] <= '0;
    end else if (tbl_we) begin
      out_mem[cfg_addr] <= cfg_out;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      care_mem[cfg_addr] <= cfg_care;
      val_mem[cfg_addr]  <= cfg_val;
    end
  end

  assign in_ready  = idle;
  assign busy      = ~idle;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sop_eval_engine.sv
// Self-checking bench for sop_eval_engine: three instances (CPC=1, CPC=4, early exit)
// driven by directed sequences, a vector table and randomized checks against a model.
module tb_sop_eval_engine;

  localparam int NI = 8;
  localparam int NO = 2;
  localparam int NC = 64;
  localparam int AW = 6;
  localparam int ND = 3;
  localparam int CPC_T [ND] = '{1, 4, 1};
  localparam bit EE_T  [ND] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          cfg_we     [ND];
  logic [AW-1:0] cfg_addr   [ND];
  logic [NI-1:0] cfg_care   [ND];
  logic [NI-1:0] cfg_val    [ND];
  logic [NO-1:0] cfg_out    [ND];
  logic          cfg_len_we [ND];
  logic [AW:0]   cfg_len    [ND];
  logic          cfg_err    [ND];
  logic          in_valid   [ND];
  logic          in_ready   [ND];
  logic [NI-1:0] in_data    [ND];
  logic          out_valid  [ND];
  logic          out_ready  [ND];
  logic [NO-1:0] out_data   [ND];
  logic          busy       [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sop_eval_engine #(
      .N_IN(NI), .N_OUT(NO), .N_CUBES(NC), .CPC(CPC_T[g]), .EARLY_EXIT(EE_T[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we[g]),
      .cfg_addr  (cfg_addr[g]),
      .cfg_care  (cfg_care[g]),
      .cfg_val   (cfg_val[g]),
      .cfg_out   (cfg_out[g]),
      .cfg_len_we(cfg_len_we[g]),
      .cfg_len   (cfg_len[g]),
      .cfg_err   (cfg_err[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference copy of each table, tracked from the bench's own writes.
  logic [NI-1:0] care_m [ND][NC];
  logic [NI-1:0] val_m  [ND][NC];
  logic [NO-1:0] out_m  [ND][NC];
  int            count_m [ND];

  typedef struct {
    logic [NI-1:0] din;
    logic [NO-1:0] dout;
    int            lat;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      count_m[d] = 0;
      for (int i = 0; i < NC; i++) begin
        care_m[d][i] = '0;
        val_m[d][i]  = '0;
        out_m[d][i]  = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic cfg_cube(input int d, input int a, input logic [NI-1:0] care,
                          input logic [NI-1:0] val, input logic [NO-1:0] o);
    cfg_we[d]   = 1'b1;
    cfg_addr[d] = AW'(a);
    cfg_care[d] = care;
    cfg_val[d]  = val;
    cfg_out[d]  = o;
    cyc();
    cfg_we[d] = 1'b0;
    care_m[d][a] = care;
    val_m[d][a]  = val;
    out_m[d][a]  = o;
  endtask

  task automatic set_len(input int d, input int len);
    cfg_len_we[d] = 1'b1;
    cfg_len[d]    = (AW+1)'(len);
    cyc();
    cfg_len_we[d] = 1'b0;
    count_m[d] = (len > NC) ? NC : len;
  endtask

  task automatic start(input int d, input logic [NI-1:0] x);
    check("in_ready_before_accept", 32'(in_ready[d]), 1);
    in_valid[d] = 1'b1;
    in_data[d]  = x;
    cyc();
    in_valid[d] = 1'b0;
  endtask

  // Latency is counted in cycles after the accept cycle T (1 means valid at T+1).
  task automatic wait_out(input int d, output int lat);
    lat = 1;
    while (out_valid[d] !== 1'b1 && lat < 200) begin
      cyc();
      lat++;
    end
    if (lat >= 200) check("out_valid_timeout", 32'(out_valid[d]), 1);
  endtask

  task automatic handshake(input int d);
    out_ready[d] = 1'b1;
    cyc();
    out_ready[d] = 1'b0;
  endtask

  task automatic run(input int d, input logic [NI-1:0] x, output logic [NO-1:0] res,
                     output int lat);
    start(d, x);
    wait_out(d, lat);
    res = out_data[d];
    handshake(d);
  endtask

  // Sum of products over the first count cubes.
  function automatic logic [NO-1:0] model_res(input int d, input logic [NI-1:0] x);
    logic [NO-1:0] r = '0;
    for (int i = 0; i < count_m[d]; i++)
      if (((x ^ val_m[d][i]) & care_m[d][i]) == '0) r |= out_m[d][i];
    return r;
  endfunction

  // Full scan takes ceil(count/CPC) cycles; early exit stops in the group where
  // the running OR first reaches all ones.
  function automatic int model_lat(input int d, input logic [NI-1:0] x);
    int groups;
    logic [NO-1:0] r = '0;
    if (count_m[d] == 0) return 1;
    groups = (count_m[d] + CPC_T[d] - 1) / CPC_T[d];
    if (EE_T[d]) begin
      for (int i = 0; i < count_m[d]; i++) begin
        if (((x ^ val_m[d][i]) & care_m[d][i]) == '0) r |= out_m[d][i];
        if (&r) return 1 + ((i / CPC_T[d] + 1 < groups) ? i / CPC_T[d] + 1 : groups);
      end
    end
    return 1 + groups;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NO-1:0] res;
    int lat;

    for (int d = 0; d < ND; d++) begin
      cfg_we[d] = 1'b0; cfg_addr[d] = '0; cfg_care[d] = '0; cfg_val[d] = '0;
      cfg_out[d] = '0; cfg_len_we[d] = 1'b0; cfg_len[d] = '0;
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
    end
    vecs[0] = '{8'h81, 2'b11, 3};
    vecs[1] = '{8'h02, 2'b00, 3};
    vecs[2] = '{8'h01, 2'b01, 3};
    vecs[3] = '{8'h80, 2'b10, 3};
    vecs[4] = '{8'hFD, 2'b11, 3};

    do_reset();
    check("reset_out_valid", 32'(out_valid[0]), 0);
    check("reset_out_data", 32'(out_data[0]), 0);
    check("reset_busy", 32'(busy[0]), 0);
    check("reset_cfg_err", 32'(cfg_err[0]), 0);

    // Reset asserted mid-scan wipes the table and count.
    cfg_cube(0, 0, 8'h00, 8'h00, 2'b11);
    set_len(0, 8);
    start(0, 8'h5A);
    cyc(2);
    check("scan_busy", 32'(busy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midscan_rst_out_valid", 32'(out_valid[0]), 0);
    check("midscan_rst_busy", 32'(busy[0]), 0);
    check("midscan_rst_in_ready", 32'(in_ready[0]), 1);
    cyc();
    rst_n = 1'b1;
    clear_model();
    cyc();
    run(0, 8'h5A, res, lat);
    check("post_rst_data", 32'(res), 0);
    check("post_rst_lat", 32'(lat), 1);

    // Basic SOP vector table.
    cfg_cube(0, 0, 8'h03, 8'h01, 2'b01);
    cfg_cube(0, 1, 8'h80, 8'h80, 2'b10);
    set_len(0, 2);
    for (int i = 0; i < 5; i++) begin
      run(0, vecs[i].din, res, lat);
      check($sformatf("sop_data[%0d]", i), 32'(res), 32'(vecs[i].dout));
      check($sformatf("sop_lat[%0d]", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held while out_ready is low.
    start(0, 8'h81);
    wait_out(0, lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_data", 32'(out_data[0]), 32'h3);
      check("bp_out_valid", 32'(out_valid[0]), 1);
      check("bp_in_ready", 32'(in_ready[0]), 0);
      cyc();
    end
    out_ready[0] = 1'b1;
    cyc();
    out_ready[0] = 1'b0;
    check("bp_release_in_ready", 32'(in_ready[0]), 1);
    check("bp_release_out_valid", 32'(out_valid[0]), 0);

    // CPC=4: only cube 9 matches, cubes past count must be ignored.
    for (int i = 0; i < 9; i++) cfg_cube(1, i, 8'hFF, 8'h00, 2'b10);
    cfg_cube(1, 9, 8'hFF, 8'h33, 2'b01);
    for (int i = 10; i < 16; i++) cfg_cube(1, i, 8'h00, 8'h00, 2'b11);
    set_len(1, 10);
    run(1, 8'h33, res, lat);
    check("cpc4_data", 32'(res), 32'h1);
    check("cpc4_lat", 32'(lat), 4);

    // Cube write, length write and accept in the same IDLE cycle.
    cfg_we[1] = 1'b1; cfg_addr[1] = '0; cfg_care[1] = 8'h00; cfg_val[1] = 8'h00;
    cfg_out[1] = 2'b10; cfg_len_we[1] = 1'b1; cfg_len[1] = 7'd4;
    start(1, 8'h33);
    cfg_we[1] = 1'b0; cfg_len_we[1] = 1'b0;
    wait_out(1, lat);
    check("same_cycle_cfg_data", 32'(out_data[1]), 32'h2);
    check("same_cycle_cfg_lat", 32'(lat), 2);
    handshake(1);

    // Early exit vs full scan with an all-ones cube at index 0.
    cfg_cube(2, 0, 8'h00, 8'h00, 2'b11);
    set_len(2, 16);
    run(2, 8'h00, res, lat);
    check("ee_data", 32'(res), 32'h3);
    check("ee_lat", 32'(lat), 2);
    cfg_cube(0, 0, 8'h00, 8'h00, 2'b11);
    set_len(0, 16);
    run(0, 8'h00, res, lat);
    check("noee_data", 32'(res), 32'h3);
    check("noee_lat", 32'(lat), 17);

    // Config writes while busy are dropped and flagged.
    start(0, 8'h81);
    cyc(2);
    cfg_we[0] = 1'b1; cfg_addr[0] = '0; cfg_care[0] = 8'hFF; cfg_val[0] = 8'h00; cfg_out[0] = 2'b00;
    cyc();
    cfg_we[0] = 1'b0;
    check("busy_we_err_pulse", 32'(cfg_err[0]), 1);
    cyc();
    check("busy_we_err_clear", 32'(cfg_err[0]), 0);
    cfg_we[0] = 1'b1; cfg_len_we[0] = 1'b1; cfg_len[0] = 7'd1;
    cyc();
    cfg_we[0] = 1'b0; cfg_len_we[0] = 1'b0;
    check("busy_both_err_pulse", 32'(cfg_err[0]), 1);
    cyc();
    check("busy_both_err_clear", 32'(cfg_err[0]), 0);
    wait_out(0, lat);
    check("busy_cfg_result", 32'(out_data[0]), 32'h3);
    handshake(0);
    run(0, 8'h81, res, lat);
    check("busy_cfg_table_kept", 32'(res), 32'h3);
    check("busy_cfg_count_kept", 32'(lat), 17);

    // Length saturates to the table depth.
    set_len(0, 100);
    run(0, 8'h02, res, lat);
    check("len_sat_data", 32'(res), 32'h3);
    check("len_sat_lat", 32'(lat), 65);

    // Randomized tables and vectors against the model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int d;
      d = $urandom_range(0, ND - 1);
      for (int k = $urandom_range(1, 4); k > 0; k--)
        cfg_cube(d, $urandom_range(0, 23), NI'($urandom & $urandom), NI'($urandom), NO'($urandom));
      if ($urandom_range(0, 2) == 0)
        set_len(d, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 24));
      for (int v = 0; v < 3; v++) begin
        logic [NI-1:0] x;
        x = NI'($urandom);
        run(d, x, res, lat);
        check($sformatf("rand_data d%0d x=%0h", d, x), 32'(res), 32'(model_res(d, x)));
        check($sformatf("rand_lat d%0d x=%0h", d, x), 32'(lat), 32'(model_lat(d, x)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
